// File: rtl/bcd_multi_counter_pkg.sv
// bcd_pkg: shared BCD digit type and limits for the multi-digit counter
package bcd_pkg;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;
  localparam int MAX_DIGITS = 8;
endpackage

// File: rtl/bcd_multi_counter_digit.sv
// bcd_digit: one registered BCD digit with load, up/down step and carry/borrow-out
module bcd_digit
  import bcd_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic step,
  input  logic up,
  input  logic load,
  input  bcd_t din,
  output bcd_t q,
  output logic co
);
  assign co = up ? q == BCD_MAX : q == BCD_MIN;
  // digit register: reset clears, load wins over step, step rolls 9<->0
  always_ff @(posedge Clock)
    if (!Reset) q <= BCD_MIN;
    else if (load) q <= din;
    else if (step) q <= up ? (q == BCD_MAX ? BCD_MIN : q + 4'd1) : (q == BCD_MIN ? BCD_MAX : q - 4'd1);
endmodule

// File: rtl/bcd_multi_counter.sv
// bcd_multi_counter: DIGITS-wide BCD up/down counter with load; BCD_MULTI_COUNTER_SAT_EN selects saturating mode
module bcd_multi_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter bit LOAD_FIX = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Enable,
  input  logic                Up,
  input  logic                Load,
  input  logic [4*DIGITS-1:0] LoadVal,
  output logic [4*DIGITS-1:0] Count,
  output logic                Wrap,
  output logic                LoadErr
);
  logic [DIGITS-1:0] step, co, bad;
  logic [4*DIGITS-1:0] load_fix;
  logic adv, any_bad, load_en, hit;
  if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_range
    $error("DIGITS out of range");
  end
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    assign bad[d] = LoadVal[4*d+:4] > BCD_MAX;
    assign load_fix[4*d+:4] = bad[d] ? BCD_MAX : LoadVal[4*d+:4];
    if (d > 0) begin : g_chain
      assign step[d] = step[d-1] & co[d-1];
    end
    bcd_digit u_digit (
      .Clock(Clock),
      .Reset(Reset),
      .step (step[d]),
      .up   (Up),
      .load (load_en),
      .din  (load_fix[4*d+:4]),
      .q    (Count[4*d+:4]),
      .co   (co[d])
    );
  end
  assign adv = Enable & ~Load;
  assign any_bad = |bad;
  assign load_en = Load & (LOAD_FIX | ~any_bad);
`ifdef BCD_MULTI_COUNTER_SAT_EN
  logic near0;
  assign near0 = Up ? Count[3:0] == BCD_MAX - 4'd1 : Count[3:0] == BCD_MIN + 4'd1;
  assign step[0] = adv & ~&co;
  assign hit = adv & near0 & &(co | DIGITS'(1));
`else
  assign step[0] = adv;
  assign hit = step[DIGITS-1] & co[DIGITS-1];
`endif
  // status pulses: Wrap on roll-over/limit hit, LoadErr on any invalid loaded nibble
  always_ff @(posedge Clock)
    if (!Reset) begin
      Wrap <= 1'b0;
      LoadErr <= 1'b0;
    end else begin
      Wrap <= hit;
      LoadErr <= Load & any_bad;
    end
endmodule

// File: tb/tb_bcd_multi_counter.sv
// tb_bcd_multi_counter: scoreboard bench over four counter configurations sharing one stimulus stream
module tb_bcd_multi_counter;
`ifdef BCD_MULTI_COUNTER_SAT_EN
  localparam bit SAT = 1;
`else
  localparam bit SAT = 0;
`endif
  typedef struct packed {
    logic [3:0][31:0] c;
    logic [3:0] w;
    logic [3:0] e;
  } exp_t;
  logic Clock = 0, Reset = 0, Enable = 0, Up = 0, Load = 0;
  logic [31:0] LoadVal = '0;
  logic [11:0] c3, c3r;
  logic [3:0] c1;
  logic [31:0] c8;
  logic [3:0] w, e;
  int checks = 0, failures = 0, cyc = 0;
  int nd[4] = '{3, 3, 1, 8};
  bit fx[4] = '{1, 0, 1, 1};
  logic [31:0] m[4] = '{0, 0, 0, 0};
  exp_t q[$];

  always #5 Clock = ~Clock;

  bcd_multi_counter #(.DIGITS(3), .LOAD_FIX(1)) dut3 (.Clock(Clock), .Reset(Reset), .Enable(Enable), .Up(Up), .Load(Load), .LoadVal(LoadVal[11:0]), .Count(c3), .Wrap(w[0]), .LoadErr(e[0]));
  bcd_multi_counter #(.DIGITS(3), .LOAD_FIX(0)) dut3r (.Clock(Clock), .Reset(Reset), .Enable(Enable), .Up(Up), .Load(Load), .LoadVal(LoadVal[11:0]), .Count(c3r), .Wrap(w[1]), .LoadErr(e[1]));
  bcd_multi_counter #(.DIGITS(1), .LOAD_FIX(1)) dut1 (.Clock(Clock), .Reset(Reset), .Enable(Enable), .Up(Up), .Load(Load), .LoadVal(LoadVal[3:0]), .Count(c1), .Wrap(w[2]), .LoadErr(e[2]));
  bcd_multi_counter #(.DIGITS(8), .LOAD_FIX(1)) dut8 (.Clock(Clock), .Reset(Reset), .Enable(Enable), .Up(Up), .Load(Load), .LoadVal(LoadVal), .Count(c8), .Wrap(w[3]), .LoadErr(e[3]));

  function automatic int b2i(logic [31:0] b, int n);
    int v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 10 + int'(b[4*i+:4]);
    return v;
  endfunction

  function automatic logic [31:0] i2b(int v, int n);
    logic [31:0] b = '0;
    for (int i = 0; i < n; i++) begin
      b[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  task automatic check_out();
    exp_t x;
    logic [3:0][31:0] ac;
    x = q.pop_front();
    ac[0] = {20'b0, c3};
    ac[1] = {20'b0, c3r};
    ac[2] = {28'b0, c1};
    ac[3] = c8;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ac[i] !== x.c[i]) begin
        failures++;
        $display("FAIL count dut%0d cyc=%0d got=%h expected=%h", i, cyc, ac[i], x.c[i]);
      end
      checks++;
      if (w[i] !== x.w[i]) begin
        failures++;
        $display("FAIL wrap dut%0d cyc=%0d got=%b expected=%b", i, cyc, w[i], x.w[i]);
      end
      checks++;
      if (e[i] !== x.e[i]) begin
        failures++;
        $display("FAIL loaderr dut%0d cyc=%0d got=%b expected=%b", i, cyc, e[i], x.e[i]);
      end
    end
  endtask

  task automatic cycle(input logic r, input logic en, input logic u, input logic ld, input logic [31:0] lv);
    exp_t x;
    int n, lim, v, nv;
    logic bad;
    logic [31:0] cl;
    Reset = r;
    Enable = en;
    Up = u;
    Load = ld;
    LoadVal = lv;
    x = '0;
    for (int i = 0; i < 4; i++) begin
      n = nd[i];
      lim = 10 ** n - 1;
      bad = 0;
      cl = '0;
      for (int j = 0; j < n; j++) begin
        if (lv[4*j+:4] > 4'd9) bad = 1;
        cl[4*j+:4] = lv[4*j+:4] > 4'd9 ? 4'd9 : lv[4*j+:4];
      end
      if (!r) m[i] = '0;
      else if (ld) begin
        x.e[i] = bad;
        if (!bad || fx[i]) m[i] = cl;
      end else if (en) begin
        v = b2i(m[i], n);
        nv = u ? (v == lim ? (SAT ? lim : 0) : v + 1) : (v == 0 ? (SAT ? 0 : lim) : v - 1);
        x.w[i] = SAT ? (nv != v && nv == (u ? lim : 0)) : (u ? v == lim : v == 0);
        m[i] = i2b(nv, n);
      end
      x.c[i] = m[i];
    end
    q.push_back(x);
    @(posedge Clock);
    #1;
    cyc++;
    check_out();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, i[0], 32'h12345678);
  endtask

  task automatic test_count_up();
    int nw = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle(1, 1, 1, 0, 0);
      nw += int'(w[0]);
    end
    checks++;
    if (nw != 1) begin
      failures++;
      $display("FAIL wrap_pulses got=%0d expected=1", nw);
    end
  endtask

  task automatic test_load_down();
    cycle(1, 0, 0, 1, 32'h00000100);
    for (int i = 0; i < 101; i++) cycle(1, 1, 0, 0, 0);
  endtask

  task automatic test_load_fix();
    cycle(1, 1, 1, 1, 32'h000001A5);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 32'hFFFFFFFF);
  endtask

  task automatic test_priority();
    cycle(1, 1, 1, 1, 32'h00000042);
    cycle(0, 1, 1, 1, 32'h00000042);
    cycle(1, 0, 0, 1, 32'h99999999);
    cycle(0, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 0);
  endtask

  task automatic test_saturation();
    cycle(1, 0, 1, 1, 32'h99999998);
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0, 0);
    cycle(1, 0, 0, 1, 32'h00000002);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0);
  endtask

  task automatic test_hold();
    cycle(1, 0, 1, 1, 32'h00000555);
    for (int i = 0; i < 6; i++) cycle(1, 0, i[0], 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(15) != 0, $urandom_range(1), $urandom_range(1), $urandom_range(7) == 0, $urandom);
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_load_down();
    test_load_fix();
    test_priority();
    test_saturation();
    test_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_multi_counter.md
BCD_MULTI_COUNTER -- requirements
Module: bcd_multi_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 3, giving the number of BCD digits; legal range 1..8.
REQ-002 SHALL have parameter LOAD_FIX, default 1; 1 = clamp loaded nibbles >9 to 9, 0 = reject the whole load.
REQ-003 SHALL have port Clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port Enable, input, 1 bit: count one step this cycle.
REQ-006 SHALL have port Up, input, 1 bit: 1 = increment, 0 = decrement.
REQ-007 SHALL have port Load, input, 1 bit: load LoadVal this cycle.
REQ-008 SHALL have port LoadVal, input, 4*DIGITS bits: BCD value to load; nibble 0 is the least-significant digit.
REQ-009 SHALL have port Count, output, 4*DIGITS bits: registered BCD count; nibble 0 is the least-significant digit.
REQ-010 SHALL have port Wrap, output, 1 bit: one-cycle registered pulse on roll-over or saturation hit.
REQ-011 SHALL have port LoadErr, output, 1 bit: one-cycle registered pulse when a load contained an invalid nibble.

Function
REQ-012 Priority SHALL be Reset > Load > Enable; Up SHALL be ignored when Enable=0.
REQ-013 With Enable=1 and Load=0, Count SHALL change by exactly 1 in BCD on the next rising edge; latency is 1 cycle.
REQ-014 Increment SHALL roll a digit 9->0 and carry into the next digit; decrement SHALL roll a digit 0->9 and borrow from the next digit; the carry/borrow chain SHALL resolve within the same cycle.
REQ-015 Count SHALL never hold a nibble >9.
REQ-016 Up past all-9s (e.g. 999) SHALL produce all-0s, with Wrap=1 for one cycle.
REQ-017 Down past all-0s SHALL produce all-9s, with Wrap=1 for one cycle.
REQ-018 Load=1 SHALL set Count to LoadVal on the next edge, regardless of Enable; no count step SHALL occur that cycle.
REQ-019 A loaded nibble >9 SHALL be clamped to 9 when LOAD_FIX=1, or the load SHALL be ignored (Count held) when LOAD_FIX=0; LoadErr SHALL pulse in both cases.
REQ-020 Wrap and LoadErr SHALL be 0 in every cycle not named above; Wrap and LoadErr SHALL never assert in the same cycle.
REQ-021 With Enable=0 and Load=0, Count SHALL hold.

Reset
REQ-022 While Reset=0 at a rising edge: Count=0, Wrap=0, LoadErr=0; Load and Enable SHALL be ignored.
REQ-023 Reset asserted mid-count SHALL clear everything on that edge; no Wrap SHALL be emitted for a pending roll-over.
REQ-024 The first count step after release SHALL occur on the first edge with Reset=1 and Enable=1.

Configuration
REQ-025 Macro BCD_MULTI_COUNTER_SAT_EN defined: saturating mode. Up at all-9s SHALL hold all-9s; down at all-0s SHALL hold all-0s; Wrap SHALL pulse only on the step that first reaches the limit, and SHALL not re-pulse while the count holds at the limit.
REQ-026 Macro BCD_MULTI_COUNTER_SAT_EN not defined: wrapping behaviour per REQ-016/017; no saturation logic SHALL be present.

Structure
REQ-027 Shared package bcd_pkg SHALL hold BCD_MAX (4'd9), BCD_MIN (4'd0), the 4-bit BCD digit typedef, and the MAX_DIGITS (8) constant.
REQ-028 SHALL instantiate sub-module bcd_digit DIGITS times. Inputs: Clock, Reset, step-in, Up, load, load nibble. Outputs: registered digit, combinational carry/borrow-out at 9 (up) or 0 (down).
REQ-029 The top level SHALL hold only the carry chain, load validation, saturation detect and the Wrap/LoadErr registers.

Verification
REQ-030 DIGITS=3: Reset=0 for 5 cycles, release, Enable=1 for 1000 cycles up -> Count steps 000..999 then 000; Wrap pulses exactly once, on the 999->000 edge.
REQ-031 DIGITS=3: Load 0x100 then Enable down 1 step -> 099; continue to 000, one more step -> 999 with Wrap=1.
REQ-032 DIGITS=3, LOAD_FIX=1: load 0x1A5 -> Count=195, LoadErr=1 for one cycle; LOAD_FIX=0 -> Count unchanged, LoadErr=1.
REQ-033 DIGITS=3: Load=1 and Enable=1 with LoadVal=0x042 -> Count=042, no step; Reset=0 in the same cycle as Load -> Count=000.
REQ-034 DIGITS=3, BCD_MULTI_COUNTER_SAT_EN defined: load 998, up 5 steps -> Count 999 held, Wrap pulses once.
REQ-035 DIGITS=1 and DIGITS=8: up-count across the top -> Count=9->0 and 99999999->00000000 respectively, with one Wrap each.
